ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 rst_i  in  1  reset, synchronous, active-high.
REQ-003 ex_valid_i  in  1  EX-stage instruction valid.
REQ-004 ex_alu_result_i  in  32  ALU result (address for lw/sw, data otherwise).
REQ-005 ex_store_data_i  in  32  forwarded rs2 value for sw.
REQ-006 ex_rd_i  in  5  destination register.
REQ-007 ex_reg_write_i, ex_mem_to_reg_i, ex_mem_read_i, ex_mem_write_i  in  1 each  control bits from ID/EX.
REQ-008 flush_i  in  1  squash the instruction being captured from EX.
REQ-009 stall_o  out  1  freeze PC, IF/ID, ID/EX and EX inputs.
REQ-010 mem_req_o, mem_we_o  out  1 each  data-memory request, write enable.
REQ-011 mem_addr_o, mem_wdata_o  out  32 each  word address, store data.
REQ-012 mem_ack_i  in  1; mem_rdata_i  in  32  memory completion, load data (valid with ack).
REQ-013 fwd_valid_o  out  1; fwd_rd_o  out  5; fwd_data_o  out  32  EX/MEM forwarding source.
REQ-014 wb_valid_o, wb_reg_write_o  out  1 each; wb_rd_o  out  5; wb_data_o  out  32  MEM/WB register to writeback.

Function
REQ-015 The EX/MEM register SHALL load all EX inputs on a rising edge when stall_o=0, storing valid = ex_valid_i & ~flush_i.
REQ-016 When stall_o=1 the EX/MEM register SHALL hold; flush_i is ignored then (upstream holds flush until stall_o=0).
REQ-017 FSM states IDLE, REQ; IDLE->REQ on the edge that loads a valid entry with mem_read or mem_write; REQ->IDLE on the edge where mem_ack_i=1, unless a new valid memory entry loads that same edge (REQ->REQ).
REQ-018 In REQ, mem_req_o=1, mem_we_o=entry mem_write, mem_addr_o={alu[31:2],2'b00}, mem_wdata_o=store data, all stable until ack.
REQ-019 stall_o SHALL be combinational: 1 iff state=REQ and mem_ack_i=0 (zero-wait-state ack in first REQ cycle causes no stall).
REQ-020 mem_ack_i in IDLE SHALL be ignored.
REQ-021 MEM/WB register SHALL load when stall_o=0: wb_valid_o=entry valid, wb_rd_o=rd, wb_data_o=mem_rdata_i if mem_to_reg else alu result; when stall_o=1 it SHALL load wb_valid_o=0 (bubble).
REQ-022 wb_reg_write_o SHALL equal entry reg_write & valid & (rd!=0); sw entries never write.
REQ-023 Latency: non-memory op captured at edge N appears on wb_* after edge N+1; memory op appears after the edge on which mem_ack_i=1.
REQ-024 fwd_valid_o SHALL be valid & reg_write & ~mem_read & (rd!=0); fwd_data_o = alu result; fwd_rd_o = rd.
REQ-025 Misaligned address bits [1:0] SHALL be ignored; no exception.

Reset
REQ-026 When rst_i=1 at an edge: state=IDLE, EX/MEM and MEM/WB contents (valid, controls, rd, data) cleared to 0; mem_req_o=0, stall_o=0, all wb_* and fwd_* outputs 0 in the following cycle.
REQ-027 Reset during REQ SHALL drop the request without awaiting ack; a later stray ack is ignored (REQ-020).

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (IDLE=0, REQ=1), data width 32, register-index width 5, and the control-bundle layout.
REQ-029 One sub-module is natural: mem_req_fsm (state, mem_req_o, stall_o); pipeline registers stay in ex_mem_stage.

Verification
REQ-030 add result 0x0000_0010 rd=5 reg_write, no mem -> wb_data_o=0x10, wb_rd_o=5, wb_reg_write_o=1 two edges later; stall_o never 1.
REQ-031 lw addr 0x0000_0103, ack after 3 cycles rdata 0xDEADBEEF -> mem_addr_o=0x100, stall_o=1 for 3 cycles, wb_data_o=0xDEADBEEF, one wb bubble per stall cycle.
REQ-032 sw addr 0x20 data 0x55, ack same cycle as request -> mem_we_o=1, stall_o=0 throughout, wb_reg_write_o=0.
REQ-033 flush_i=1 with valid add rd=7 -> wb_valid_o=0, fwd_valid_o=0; flush_i asserted while stalled -> ignored, pending lw completes.
REQ-034 rst_i=1 during REQ with no ack, then ack 2 cycles later -> mem_req_o=0 after reset edge, state IDLE, no wb write.
REQ-035 add rd=0 result 0x1234 -> wb_reg_write_o=0, fwd_valid_o=0.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg
// Shared definitions for the EX/MEM pipeline stage:
//   - data and register-index widths
//   - memory-request FSM state encoding (IDLE=0, REQ=1)
//   - control-bundle layout carried from ID/EX into EX/MEM
//   - word-address helper used to drop the byte offset of an address
package ex_mem_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } mem_state_e;

    // Bit order is {reg_write, mem_to_reg, mem_read, mem_write}.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

    // Misaligned low bits are silently discarded; no exception is raised.
    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] addr);
        return {addr[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ex_mem_stage_mem_req_fsm.sv
// mem_req_fsm
// Two-state data-memory request controller for the EX/MEM stage.
// Handshake: mem_req_o is held high from the cycle after a memory entry
// is captured until the cycle in which mem_ack_i=1; the transfer
// completes on that rising edge. mem_ack_i outside REQ is ignored.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   load_mem_i      the coming edge captures a valid lw/sw entry
//   mem_ack_i       memory completion
//   mem_req_o       request outstanding (state == REQ)
//   stall_o         REQ and no ack yet; freezes the upstream pipeline
//   dbg_state_o     current FSM state
module mem_req_fsm
    import ex_mem_stage_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       load_mem_i,
    input  logic       mem_ack_i,
    output logic       mem_req_o,
    output logic       stall_o,
    output mem_state_e dbg_state_o
);

    mem_state_e state_q;
    mem_state_e state_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req_o = 1'b0;
        stall_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_mem_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                mem_req_o = 1'b1;
                stall_o   = ~mem_ack_i;
                // A new memory entry captured on the ack edge issues
                // back-to-back without passing through IDLE.
                if (mem_ack_i) begin
                    state_d = load_mem_i ? ST_REQ : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dbg_state_o = state_q;

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage
// EX/MEM pipeline register, data-memory interface and MEM/WB register.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   ex_*                             instruction arriving from EX
//   flush_i                          squash the instruction being captured
//   stall_o                          freeze PC, IF/ID, ID/EX and EX inputs
//   mem_req_o/we_o/addr_o/wdata_o    data-memory request (word address)
//   mem_ack_i, mem_rdata_i           completion and load data
//   fwd_valid_o/rd_o/data_o          EX/MEM forwarding source
//   wb_valid_o/reg_write_o/rd_o/data_o  MEM/WB register to writeback
//   dbg_state_o                      memory-request FSM state
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic [DATA_W-1:0] ex_alu_result_i,
    input  logic [DATA_W-1:0] ex_store_data_i,
    input  logic [REG_W-1:0]  ex_rd_i,
    input  logic              ex_reg_write_i,
    input  logic              ex_mem_to_reg_i,
    input  logic              ex_mem_read_i,
    input  logic              ex_mem_write_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              fwd_valid_o,
    output logic [REG_W-1:0]  fwd_rd_o,
    output logic [DATA_W-1:0] fwd_data_o,
    output logic              wb_valid_o,
    output logic              wb_reg_write_o,
    output logic [REG_W-1:0]  wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output mem_state_e        dbg_state_o
);

    ctrl_t             ex_ctrl;
    logic              load_mem;

    logic              ent_valid;
    ctrl_t             ent_ctrl;
    logic [REG_W-1:0]  ent_rd;
    logic [DATA_W-1:0] ent_alu;
    logic [DATA_W-1:0] ent_store;

    assign ex_ctrl = {ex_reg_write_i, ex_mem_to_reg_i, ex_mem_read_i, ex_mem_write_i};

    // stall_o depends only on FSM state and ack, so this has no comb loop.
    assign load_mem = ~stall_o & ex_valid_i & ~flush_i & (ex_mem_read_i | ex_mem_write_i);

    mem_req_fsm u_fsm (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_mem_i  (load_mem),
        .mem_ack_i   (mem_ack_i),
        .mem_req_o   (mem_req_o),
        .stall_o     (stall_o),
        .dbg_state_o (dbg_state_o)
    );

    // EX/MEM register: holds while stalled; flush only acts on a load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent_valid <= 1'b0;
            ent_ctrl  <= '0;
            ent_rd    <= '0;
            ent_alu   <= '0;
            ent_store <= '0;
        end else if (!stall_o) begin
            ent_valid <= ex_valid_i & ~flush_i;
            ent_ctrl  <= ex_ctrl;
            ent_rd    <= ex_rd_i;
            ent_alu   <= ex_alu_result_i;
            ent_store <= ex_store_data_i;
        end
    end

    // The request fields come straight from the held entry, so they stay
    // stable for as long as the request is outstanding.
    assign mem_we_o    = mem_req_o & ent_ctrl.mem_write;
    assign mem_addr_o  = word_addr(ent_alu);
    assign mem_wdata_o = ent_store;

    // Loads are excluded: their result is not known until the ack.
    assign fwd_valid_o = ent_valid & ent_ctrl.reg_write & ~ent_ctrl.mem_read & (ent_rd != '0);
    assign fwd_rd_o    = ent_rd;
    assign fwd_data_o  = ent_alu;

    // MEM/WB register: a stalled cycle inserts a bubble. A load entry only
    // leaves EX/MEM on the ack edge, so mem_rdata_i is valid when sampled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
        end else if (!stall_o) begin
            wb_valid_o     <= ent_valid;
            wb_reg_write_o <= ent_valid & ent_ctrl.reg_write & (ent_rd != '0);
            wb_rd_o        <= ent_rd;
            wb_data_o      <= ent_ctrl.mem_to_reg ? mem_rdata_i : ent_alu;
        end else begin
            wb_valid_o     <= 1'b0;
            wb_reg_write_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage
// Per-cycle vector table for ex_mem_stage: each record holds the inputs
// driven for one cycle and the outputs expected during that same cycle
// (combinational outputs plus registered outputs from earlier edges).
// Reset behaviour and reset-during-request are hand-written sequences.
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;
    localparam logic [3:0] C_NONE = 4'b0000;
    localparam logic [3:0] C_ALU  = 4'b1000;
    localparam logic [3:0] C_LW   = 4'b1110;
    localparam logic [3:0] C_SW   = 4'b0001;
    localparam logic [31:0] Z32 = 32'h0;
    localparam logic [4:0]  Z5  = 5'd0;

    typedef struct {
        logic        ev;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctl;
        logic        fl;
        logic        ack;
        logic [31:0] rdata;
        logic        e_stall;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic        e_fv;
        logic [4:0]  e_frd;
        logic [31:0] e_fd;
        logic        e_wv;
        logic        e_wrw;
        logic [4:0]  e_wrd;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, flush;
    logic [31:0] ex_alu, ex_store;
    logic [4:0]  ex_rd;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        fwd_valid, wb_valid, wb_reg_write;
    logic [4:0]  fwd_rd, wb_rd;
    logic [31:0] fwd_data, wb_data;
    mem_state_e  dut_state;

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .ex_valid_i      (ex_valid),
        .ex_alu_result_i (ex_alu),
        .ex_store_data_i (ex_store),
        .ex_rd_i         (ex_rd),
        .ex_reg_write_i  (ex_reg_write),
        .ex_mem_to_reg_i (ex_mem_to_reg),
        .ex_mem_read_i   (ex_mem_read),
        .ex_mem_write_i  (ex_mem_write),
        .flush_i         (flush),
        .stall_o         (stall),
        .mem_req_o       (mem_req),
        .mem_we_o        (mem_we),
        .mem_addr_o      (mem_addr),
        .mem_wdata_o     (mem_wdata),
        .mem_ack_i       (mem_ack),
        .mem_rdata_i     (mem_rdata),
        .fwd_valid_o     (fwd_valid),
        .fwd_rd_o        (fwd_rd),
        .fwd_data_o      (fwd_data),
        .wb_valid_o      (wb_valid),
        .wb_reg_write_o  (wb_reg_write),
        .wb_rd_o         (wb_rd),
        .wb_data_o       (wb_data),
        .dbg_state_o     (dut_state)
    );

    // scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic ev, input logic [31:0] alu, input logic [31:0] sd,
                         input logic [4:0] rd, input logic [3:0] ctl, input logic fl,
                         input logic ack, input logic [31:0] rdata);
        ex_valid      = ev;
        ex_alu        = alu;
        ex_store      = sd;
        ex_rd         = rd;
        ex_reg_write  = ctl[3];
        ex_mem_to_reg = ctl[2];
        ex_mem_read   = ctl[1];
        ex_mem_write  = ctl[0];
        flush         = fl;
        mem_ack       = ack;
        mem_rdata     = rdata;
    endtask

    task automatic drive_idle();
        drive(N, Z32, Z32, Z5, C_NONE, N, N, Z32);
    endtask

    task automatic add_vec(input logic ev, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic [3:0] ctl, input logic fl,
                           input logic ack, input logic [31:0] rdata,
                           input logic e_stall, input logic e_req, input logic e_we,
                           input logic [31:0] e_addr, input logic [31:0] e_wdata,
                           input logic e_fv, input logic [4:0] e_frd, input logic [31:0] e_fd,
                           input logic e_wv, input logic e_wrw, input logic [4:0] e_wrd,
                           input logic [31:0] e_wd);
        vec_t v;
        v.ev = ev; v.alu = alu; v.sd = sd; v.rd = rd; v.ctl = ctl; v.fl = fl;
        v.ack = ack; v.rdata = rdata;
        v.e_stall = e_stall; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wdata = e_wdata;
        v.e_fv = e_fv; v.e_frd = e_frd; v.e_fd = e_fd;
        v.e_wv = e_wv; v.e_wrw = e_wrw; v.e_wrd = e_wrd; v.e_wd = e_wd;
        vecs.push_back(v);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " stall"}, 32'(stall), 32'(N));
        chk({tag, " mem_req"}, 32'(mem_req), 32'(N));
        chk({tag, " state"}, 32'(dut_state), 32'(ST_IDLE));
        chk({tag, " fwd_valid"}, 32'(fwd_valid), 32'(N));
        chk({tag, " wb_valid"}, 32'(wb_valid), 32'(N));
        chk({tag, " wb_reg_write"}, 32'(wb_reg_write), 32'(N));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //    ev alu           sd            rd     ctl     fl ack rdata
        //    stall req we addr        wdata         fv frd   fd            wv wrw wrd  wd
        // add rd5 0x10 -> forwarded next cycle, written back the cycle after
        add_vec(Y, 32'h10, Z32, 5'd5, C_ALU, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, Y, 5'd5, 32'h10, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, Y, Y, 5'd5, 32'h10);
        // lw 0x103 rd9, three wait states; an add rd3 is held upstream
        add_vec(Y, 32'h103, 32'hAAAA0000, 5'd9, C_LW, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(Y, 32'h77, Z32, 5'd3, C_ALU, N, N, Z32,
                Y, Y, N, 32'h100, 32'hAAAA0000, N, Z5, Z32, N, N, Z5, Z32);
        // flush while stalled is ignored
        add_vec(Y, 32'h77, Z32, 5'd3, C_ALU, Y, N, Z32,
                Y, Y, N, 32'h100, 32'hAAAA0000, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(Y, 32'h77, Z32, 5'd3, C_ALU, N, N, Z32,
                Y, Y, N, 32'h100, 32'hAAAA0000, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(Y, 32'h77, Z32, 5'd3, C_ALU, N, Y, 32'hDEADBEEF,
                N, Y, N, 32'h100, 32'hAAAA0000, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, Y, 5'd3, 32'h77, Y, Y, 5'd9, 32'hDEADBEEF);
        // sw 0x20 data 0x55 with zero-wait ack
        add_vec(Y, 32'h20, 32'h55, 5'd12, C_SW, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, Y, Y, 5'd3, 32'h77);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, Y, Z32,
                N, Y, Y, 32'h20, 32'h55, N, Z5, Z32, N, N, Z5, Z32);
        // flushed add rd7, then add rd0
        add_vec(Y, 32'h99, Z32, 5'd7, C_ALU, Y, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, Y, N, 5'd12, 32'h20);
        add_vec(Y, 32'h1234, Z32, Z5, C_ALU, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, Y, N, Z5, 32'h1234);
        // back-to-back loads: second captured on the first one's ack edge
        add_vec(Y, 32'h200, Z32, 5'd4, C_LW, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(Y, 32'h305, Z32, 5'd6, C_LW, N, Y, 32'h11112222,
                N, Y, N, 32'h200, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                Y, Y, N, 32'h304, Z32, N, Z5, Z32, Y, Y, 5'd4, 32'h11112222);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, Y, 32'h33334444,
                N, Y, N, 32'h304, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, Y, Y, 5'd6, 32'h33334444);
        // stray ack in IDLE
        add_vec(N, Z32, Z32, Z5, C_NONE, N, Y, 32'hBAD0BAD0,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);
        add_vec(N, Z32, Z32, Z5, C_NONE, N, N, Z32,
                N, N, N, Z32, Z32, N, Z5, Z32, N, N, Z5, Z32);

        // reset
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("reset");
        chk("reset wb_rd", 32'(wb_rd), 32'h0);
        chk("reset wb_data", wb_data, 32'h0);
        chk("reset fwd_data", fwd_data, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].ev, vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].ctl,
                  vecs[i].fl, vecs[i].ack, vecs[i].rdata);
            #1;
            chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
                chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].e_addr);
                chk($sformatf("v%0d mem_wdata", i), mem_wdata, vecs[i].e_wdata);
            end
            chk($sformatf("v%0d fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].e_fv));
            if (vecs[i].e_fv) begin
                chk($sformatf("v%0d fwd_rd", i), 32'(fwd_rd), 32'(vecs[i].e_frd));
                chk($sformatf("v%0d fwd_data", i), fwd_data, vecs[i].e_fd);
            end
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wv));
            chk($sformatf("v%0d wb_reg_write", i), 32'(wb_reg_write), 32'(vecs[i].e_wrw));
            if (vecs[i].e_wv) begin
                chk($sformatf("v%0d wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_wrd));
                chk($sformatf("v%0d wb_data", i), wb_data, vecs[i].e_wd);
            end
        end

        // reset while a load is outstanding, then a late stray ack
        @(negedge clk);
        drive(Y, 32'h40, Z32, 5'd8, C_LW, N, N, Z32);
        @(negedge clk);
        drive_idle();
        #1;
        chk("rstreq mem_req before", 32'(mem_req), 32'(Y));
        chk("rstreq stall before", 32'(stall), 32'(Y));
        chk("rstreq state before", 32'(dut_state), 32'(ST_REQ));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_quiet("rstreq after");
        @(negedge clk);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        #1;
        check_quiet("rstreq late ack");
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        check_quiet("rstreq after ack");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
